fnd_scan_controller: RTL and testbench



---
 rtl/fnd_pkg.sv | 28 ++
 rtl/bin2bcd_seq.sv | 112 +++++++++++
 rtl/fnd_scan_controller.sv | 77 +++++++
 tb/tb_fnd_scan_controller.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared constants, FSM state type and the double-dabble adjust step for
// the FND scan path.
package fnd_pkg;

  localparam int unsigned FND_DIGITS    = 4;
  localparam int unsigned BCD_W         = 4;
  localparam int unsigned BCD16_W       = FND_DIGITS * BCD_W;
  localparam logic [13:0] FND_MAX_VALUE = 14'd9999;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_t;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the next shift.
  function automatic logic [BCD16_W-1:0] dabble_adjust(input logic [BCD16_W-1:0] bcd);
    logic [BCD16_W-1:0] res;
    res = bcd;
    for (int unsigned i = 0; i < FND_DIGITS; i++) begin
      if (bcd[i*BCD_W +: BCD_W] >= BCD_W'(5)) begin
        res[i*BCD_W +: BCD_W] = bcd[i*BCD_W +: BCD_W] + BCD_W'(3);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter with a 9999 clamp.
// Ports:
//   i_clk, i_reset_n : clock, async active-low reset
//   i_value, i_load  : value to convert, single-cycle convert request
//   o_bcd16          : displayed digits {d3,d2,d1,d0}, updated only in DONE
//   o_busy           : high in SHIFT and DONE
//   o_done           : one-cycle pulse while in DONE
//   o_ovf            : sticky, last accepted value exceeded 9999
module bin2bcd_seq
  import fnd_pkg::*;
#(
  parameter int unsigned WIDTH = 14
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [WIDTH-1:0]   i_value,
  input  logic               i_load,
  output logic [BCD16_W-1:0] o_bcd16,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_ovf
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned SR_W  = BCD16_W + WIDTH;
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(FND_MAX_VALUE);

  conv_state_t        state_q, state_d;
  logic [BCD16_W-1:0] bcd_q,  bcd_d;
  logic [WIDTH-1:0]   src_q,  src_d;
  logic [CNT_W-1:0]   bit_q,  bit_d;
  logic [BCD16_W-1:0] disp_q, disp_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ovf_q,  ovf_d;
  logic [SR_W-1:0]    shifted;

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      src_q   <= '0;
      bit_q   <= '0;
      disp_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      src_q   <= src_d;
      bit_q   <= bit_d;
      disp_q  <= disp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and next-output logic; busy/done are set one edge early so
  // they are registered yet line up with the state they describe.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    src_d   = src_q;
    bit_d   = bit_q;
    disp_d  = disp_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    shifted = {dabble_adjust(bcd_q), src_q} << 1;

    case (state_q)
      IDLE: begin
        if (i_load) begin
          ovf_d   = (i_value > MAX_V);
          src_d   = (i_value > MAX_V) ? MAX_V : i_value;
          bcd_d   = '0;
          bit_d   = CNT_W'(WIDTH - 1);
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = shifted[SR_W-1 -: BCD16_W];
        src_d = shifted[WIDTH-1:0];
        if (bit_q == '0) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          bit_d = bit_q - CNT_W'(1);
        end
      end
      DONE: begin
        disp_d  = bcd_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign o_bcd16 = disp_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_ovf   = ovf_q;

endmodule

// File: rtl/fnd_scan_controller.sv
// 4-digit FND scan controller: converts a binary value to BCD, scans the
// digits at SCAN_HZ and blanks leading zeros.
// Ports:
//   i_clk, i_reset_n : clock, async active-low reset
//   i_value, i_load  : binary value and single-cycle convert request
//   i_en             : global display enable
//   o_digitSelect    : scanned digit index (0 = ones), registered
//   o_bcd            : BCD digit for o_digitSelect
//   o_en             : per-digit enable after leading-zero blanking
//   o_busy, o_done, o_ovf : converter status
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned SCAN_HZ = 1_000,
  parameter int unsigned WIDTH   = 14
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_load,
  input  logic             i_en,
  output logic [1:0]       o_digitSelect,
  output logic [BCD_W-1:0] o_bcd,
  output logic             o_en,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_ovf
);

  localparam int unsigned PRESC_MAX = CLK_HZ / SCAN_HZ - 1;
  localparam int unsigned PRESC_W   = (PRESC_MAX > 1) ? $clog2(PRESC_MAX + 1) : 1;
  localparam int unsigned IDX_W     = $clog2(FND_DIGITS);

  logic [PRESC_W-1:0] presc_q;
  logic [IDX_W-1:0]   idx_q;
  logic [BCD16_W-1:0] bcd16;
  logic [BCD_W-1:0]   digits [FND_DIGITS];
  logic [FND_DIGITS-1:0] nz_from;

  bin2bcd_seq #(
    .WIDTH(WIDTH)
  ) u_bin2bcd (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_value  (i_value),
    .i_load   (i_load),
    .o_bcd16  (bcd16),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_ovf    (o_ovf)
  );

  // Free-running scan prescaler and digit index.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (presc_q == PRESC_W'(PRESC_MAX)) begin
      presc_q <= '0;
      idx_q   <= (idx_q == IDX_W'(FND_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end else begin
      presc_q <= presc_q + PRESC_W'(1);
    end
  end

  // nz_from[k]: some digit at position k or above is nonzero.
  for (genvar k = 0; k < FND_DIGITS; k++) begin : g_digit
    assign digits[k]  = bcd16[k*BCD_W +: BCD_W];
    assign nz_from[k] = |bcd16[BCD16_W-1 : k*BCD_W];
  end

  assign o_digitSelect = idx_q;
  assign o_bcd         = digits[idx_q];
  assign o_en          = i_en & ((idx_q == '0) | nz_from[idx_q]);

endmodule

// File: tb/tb_fnd_scan_controller.sv
module tb_fnd_scan_controller;

  localparam int unsigned CLK_HZ  = 1000;
  localparam int unsigned SCAN_HZ = 250;
  localparam int          PRESC   = CLK_HZ / SCAN_HZ;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] i_value;
  logic        i_load;
  logic        i_en;
  logic [1:0]  o_digitSelect;
  logic [3:0]  o_bcd;
  logic        o_en, o_busy, o_done, o_ovf;

  int pass_cnt = 0;
  int total_cnt = 0;

  fnd_scan_controller #(
    .CLK_HZ (CLK_HZ),
    .SCAN_HZ(SCAN_HZ),
    .WIDTH  (14)
  ) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_value      (i_value),
    .i_load       (i_load),
    .i_en         (i_en),
    .o_digitSelect(o_digitSelect),
    .o_bcd        (o_bcd),
    .o_en         (o_en),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_ovf        (o_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s t=%0t got=%0d exp=%0d", nm, $time, act, exp);
  endtask

  function automatic int p10(input int i);
    int r = 1;
    for (int j = 0; j < i; j++) r = r * 10;
    return r;
  endfunction

  // Reference model: displayed value as an integer, conversion as a countdown
  // of remaining busy cycles, scan position from a tick counter.
  int m_pre, m_idx, m_cnt, m_val, m_pend;
  bit m_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pre = 0; m_idx = 0; m_cnt = 0; m_val = 0; m_pend = 0; m_ovf = 0;
    end else begin
      if (m_pre == PRESC - 1) begin
        m_pre = 0;
        m_idx = (m_idx + 1) % 4;
      end else begin
        m_pre = m_pre + 1;
      end
      if (m_cnt > 0) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) m_val = m_pend;
      end else if (i_load) begin
        m_ovf  = (int'(i_value) > 9999);
        m_pend = m_ovf ? 9999 : int'(i_value);
        m_cnt  = 15;
      end
    end
  end

  // Every cycle: compare all outputs against the model.
  always @(negedge clk) begin
    chk("m_sel",  int'(o_digitSelect), m_idx);
    chk("m_bcd",  int'(o_bcd), (m_val / p10(m_idx)) % 10);
    chk("m_en",   int'(o_en), int'(i_en && (m_idx == 0 || m_val >= p10(m_idx))));
    chk("m_busy", int'(o_busy), int'(m_cnt > 0));
    chk("m_done", int'(o_done), int'(m_cnt == 1));
    chk("m_ovf",  int'(o_ovf), int'(m_ovf));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_load(input int v);
    for (int k = 0; k < 40 && m_cnt != 0; k++) tick();
    i_value = 14'(v);
    i_load  = 1'b1;
    tick();
    i_load  = 1'b0;
  endtask

  typedef struct {
    int          value;
    logic [15:0] exp_bcd;
    logic [3:0]  exp_en;
    logic        exp_ovf;
  } vec_t;

  vec_t tv[9];
  int   lat, si, dcount;
  logic [3:0] seen;

  initial begin
    tv[0] = '{1234,  16'h1234, 4'b1111, 1'b0};
    tv[1] = '{7,     16'h0007, 4'b0001, 1'b0};
    tv[2] = '{0,     16'h0000, 4'b0001, 1'b0};
    tv[3] = '{12000, 16'h9999, 4'b1111, 1'b1};
    tv[4] = '{5,     16'h0005, 4'b0001, 1'b0};
    tv[5] = '{10,    16'h0010, 4'b0011, 1'b0};
    tv[6] = '{999,   16'h0999, 4'b0111, 1'b0};
    tv[7] = '{9999,  16'h9999, 4'b1111, 1'b0};
    tv[8] = '{10000, 16'h9999, 4'b1111, 1'b1};

    rst_n = 1'b0; i_value = '0; i_load = 1'b0; i_en = 1'b1;

    // Reset / idle scan
    tick(); tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("idle_sel", int'(o_digitSelect), (k / 4) % 4);
      chk("idle_bcd", int'(o_bcd), 0);
      chk("idle_en",  int'(o_en), int'(((k / 4) % 4) == 0));
    end
    tick();

    // Table-driven conversions
    for (int t = 0; t < 9; t++) begin
      apply_load(tv[t].value);
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk);
        if (o_done) begin lat = k; break; end
      end
      chk("latency", lat, 15);
      tick();
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        si = int'(o_digitSelect);
        chk("tbl_bcd", int'(o_bcd), int'(tv[t].exp_bcd[si*4 +: 4]));
        chk("tbl_en",  int'(o_en),  int'(tv[t].exp_en[si]));
      end
      chk("tbl_ovf", int'(o_ovf), int'(tv[t].exp_ovf));
      tick();
    end

    // Load while busy is ignored
    apply_load(4321);
    tick(); tick();
    i_value = 14'd1111; i_load = 1'b1;
    tick();
    i_load = 1'b0;
    dcount = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (o_done) dcount++;
    end
    chk("busy_one_done", dcount, 1);
    tick();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      si = int'(o_digitSelect);
      chk("busy_digit", int'(o_bcd), (4321 / p10(si)) % 10);
    end
    tick();
    i_en = 1'b0;
    seen = '0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      seen[o_digitSelect] = 1'b1;
      chk("en_off", int'(o_en), 0);
    end
    chk("scan_runs", int'(seen), 15);
    tick();
    i_en = 1'b1;

    // Reset mid-conversion
    apply_load(9876);
    for (int k = 0; k < 5; k++) tick();
    rst_n = 1'b0;
    dcount = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (o_done) dcount++;
      tick();
    end
    rst_n = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (o_done) dcount++;
      chk("rst_bcd",  int'(o_bcd), 0);
      chk("rst_busy", int'(o_busy), 0);
    end
    chk("rst_no_done", dcount, 0);
    tick();

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      i_load = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0: i_value = 14'($urandom_range(0, 9));
        1: i_value = 14'($urandom_range(0, 999));
        2: i_value = 14'($urandom_range(0, 9999));
        default: i_value = 14'($urandom_range(10000, 16383));
      endcase
      if ($urandom_range(0, 15) == 0) i_en = ~i_en;
      tick();
    end
    i_load = 1'b0;
    i_en   = 1'b1;
    for (int k = 0; k < 20; k++) tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
